hilo_muldiv: RTL

Parametrised, multi-cycle multiply/divide unit with architectural Hi/Lo registers. It succeeds the single-cycle ALU-plus-HiLoRegister pairing in the processor top. It runs MULT/MULTU/DIV/DIVU iteratively, one bit per cycle, and signals completion so the datapath can stall. It sits beside the ALU: operands come from the register-file read ports, and the Hi/Lo results feed the MFHI/MFLO path.

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_sign_fix.sv | 20 ++
 rtl/hilo_muldiv.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the Hi/Lo multiply/divide unit: operation codes,
// controller states and small operation-decoding helpers.
package muldiv_pkg;

   // Operation encodings presented on the Op port
   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   // Controller states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_e;

   // Signed variants (MULT, DIV) have a zero in the low opcode bit
   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

   // Divide variants (DIV, DIVU) have a one in the high opcode bit
   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate. Used both to take operand magnitudes
// on entry and to restore result signs on exit.
module muldiv_sign_fix #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] val_i,
   input  logic             neg_i,
   output logic [WIDTH-1:0] val_o
);

   // Negation wraps modulo 2^WIDTH, so the most negative value maps to itself,
   // which read as unsigned is exactly its magnitude
   always_comb begin
      val_o = val_i;
      if (neg_i) begin
         val_o = -val_i;
      end
   end

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative multiply/divide unit with architectural Hi/Lo registers.
// Operands are reduced to magnitudes on Start, processed one bit per cycle
// (shift-add multiply, restoring divide), and sign-corrected in the final
// FIX cycle where Hi/Lo are written and Done pulses.
module hilo_muldiv
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             HiWrite,
   input  logic [WIDTH-1:0] HiData,
   input  logic             LoWrite,
   input  logic [WIDTH-1:0] LoData,
   output logic             Busy,
   output logic             Done,
   output logic             DivZero,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   // Control state (reset)
   state_e             state_q, state_d;
   logic [CW-1:0]      count_q, count_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               divzero_q, divzero_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   // Datapath state (not reset; only meaningful between Start and FIX)
   logic [1:0]         op_q, op_d;
   logic [WIDTH:0]     mag_a_q, mag_a_d;
   logic [WIDTH:0]     mag_b_q, mag_b_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic               neg_ab_q, neg_ab_d;
   logic               neg_a_q, neg_a_d;
   logic               bzero_q, bzero_d;
   logic [WIDTH-1:0]   a_orig_q, a_orig_d;

   // Operand sign handling on entry
   logic               in_signed;
   logic               a_neg_in;
   logic               b_neg_in;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;

   // Per-iteration datapath terms
   logic [2*WIDTH-1:0] mul_addend;
   logic [WIDTH:0]     div_shift;
   logic               div_ge;
   logic [WIDTH-1:0]   div_diff;

   // Sign-corrected results used at FIX
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   assign in_signed = op_is_signed(Op);
   assign a_neg_in  = in_signed & A[WIDTH-1];
   assign b_neg_in  = in_signed & B[WIDTH-1];

   muldiv_sign_fix #(.WIDTH(WIDTH)) u_abs_a (
      .val_i (A),
      .neg_i (a_neg_in),
      .val_o (abs_a)
   );

   muldiv_sign_fix #(.WIDTH(WIDTH)) u_abs_b (
      .val_i (B),
      .neg_i (b_neg_in),
      .val_o (abs_b)
   );

   muldiv_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (
      .val_i (acc_q),
      .neg_i (neg_ab_q),
      .val_o (prod_fix)
   );

   muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (
      .val_i (acc_q[WIDTH-1:0]),
      .neg_i (neg_ab_q),
      .val_o (quo_fix)
   );

   muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
      .val_i (acc_q[2*WIDTH-1:WIDTH]),
      .neg_i (neg_a_q),
      .val_o (rem_fix)
   );

   // Iteration datapath: multiplicand shifted to the current multiplier bit
   // position; for divide, the {remainder, dividend} pair shifted left by one
   // and trial-subtracted against the divisor. The remainder stays below the
   // divisor, so the W-bit difference is exact whenever the trial succeeds.
   always_comb begin
      mul_addend = '0;
      if (mag_b_q[count_q]) begin
         mul_addend = {{(WIDTH-1){1'b0}}, mag_a_q} << count_q;
      end
      div_shift = acc_q[2*WIDTH-1:WIDTH-1];
      div_ge    = (div_shift >= mag_b_q);
      div_diff  = div_shift[WIDTH-1:0] - mag_b_q[WIDTH-1:0];
   end

   // Next-state and output logic for the IDLE/RUN/FIX controller
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      divzero_d = 1'b0;
      hi_d      = hi_q;
      lo_d      = lo_q;
      op_d      = op_q;
      mag_a_d   = mag_a_q;
      mag_b_d   = mag_b_q;
      acc_d     = acc_q;
      neg_ab_d  = neg_ab_q;
      neg_a_d   = neg_a_q;
      bzero_d   = bzero_q;
      a_orig_d  = a_orig_q;

      unique case (state_q)
         IDLE: begin
            // MTHI/MTLO only land while idle; a result written at FIX
            // later overwrites anything loaded alongside Start
            if (HiWrite) hi_d = HiData;
            if (LoWrite) lo_d = LoData;
            if (Start) begin
               op_d     = Op;
               mag_a_d  = {1'b0, abs_a};
               mag_b_d  = {1'b0, abs_b};
               neg_ab_d = a_neg_in ^ b_neg_in;
               neg_a_d  = a_neg_in;
               bzero_d  = op_is_div(Op) & (B == '0);
               a_orig_d = A;
               // Divide keeps the dividend in the low half and shifts it
               // into the remainder; multiply accumulates from zero
               acc_d    = op_is_div(Op) ? {{WIDTH{1'b0}}, abs_a} : '0;
               count_d  = '0;
               busy_d   = 1'b1;
               state_d  = RUN;
            end
         end

         RUN: begin
            if (op_is_div(op_q)) begin
               if (div_ge) begin
                  acc_d = {div_diff, acc_q[WIDTH-2:0], 1'b1};
               end else begin
                  acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
               end
            end else begin
               acc_d = acc_q + mul_addend;
            end
            if (count_q == CW'(WIDTH - 1)) begin
               state_d = FIX;
            end else begin
               count_d = count_q + CW'(1);
            end
         end

         FIX: begin
            if (op_is_div(op_q)) begin
               if (bzero_q) begin
                  lo_d      = '1;
                  hi_d      = a_orig_q;
                  divzero_d = 1'b1;
               end else begin
                  lo_d = quo_fix;
                  hi_d = rem_fix;
               end
            end else begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end

         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // Control registers and architectural Hi/Lo, cleared by reset
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q   <= IDLE;
         count_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         divzero_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         divzero_q <= divzero_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   // Datapath registers; contents are don't-care outside an operation
   always_ff @(posedge Clk) begin
      op_q     <= op_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      acc_q    <= acc_d;
      neg_ab_q <= neg_ab_d;
      neg_a_q  <= neg_a_d;
      bzero_q  <= bzero_d;
      a_orig_q <= a_orig_d;
   end

   assign Busy    = busy_q;
   assign Done    = done_q;
   assign DivZero = divzero_q;
   assign Hi      = hi_q;
   assign Lo      = lo_q;

endmodule
